// File: rtl/traffic_ctrl_pkg.sv
// traffic_ctrl_pkg: shared types for the intersection sequencer.
// Holds the phase encoding and the one-hot {R,Y,G} light codes.
package traffic_ctrl_pkg;

  typedef enum logic [2:0] {
    MAIN_GRN,
    MAIN_YEL,
    ALLRED1,
    WALK,
    SIDE_GRN,
    SIDE_YEL,
    ALLRED2
  } state_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/timer.sv
// timer: N-bit down counter, loadable, saturating at zero.
// Ports: clk, rst (async high), load, en, init in; count out.
module timer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] init,
  output logic [N-1:0] count
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = init;
    else if (en && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '1;
    else
      cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: Moore phase sequencer for a two-road crossing
// with pedestrian walk. In: clk, rst, tick, sensor, walk_req.
// Out: main/side lights, walk_light, walk_pend, timer_out.
module traffic_ctrl
  import traffic_ctrl_pkg::*;
#(
  parameter int          N        = 4,
  parameter int unsigned T_GREEN  = 8,
  parameter int unsigned T_YEL    = 3,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_SIDE   = 6,
  parameter int unsigned T_WALK   = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         sensor,
  input  logic         walk_req,
  output logic [2:0]   main_light,
  output logic [2:0]   side_light,
  output logic         walk_light,
  output logic         walk_pend,
  output logic [N-1:0] timer_out
);

  state_e       state_q, state_d;
  logic         load_q, load_d;
  logic         wpend_q, wpend_d;
  logic [N-1:0] init;
  logic         expire;

  // Ticks landing on the load cycle are dropped.
  timer #(.N(N)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load_q),
    .en    (tick & ~load_q),
    .init  (init),
    .count (timer_out)
  );

  assign expire = (timer_out == '0) & ~load_q;

  always_comb begin
    unique case (state_q)
      MAIN_GRN: init = N'(T_GREEN);
      MAIN_YEL,
      SIDE_YEL: init = N'(T_YEL);
      WALK:     init = N'(T_WALK);
      SIDE_GRN: init = N'(T_SIDE);
      default:  init = N'(T_ALLRED);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MAIN_GRN;
      load_q  <= 1'b1;
      wpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      wpend_q <= wpend_d;
    end
  end

  // Idle main green holds at zero with no reload
  // until a car or pedestrian shows up.
  always_comb begin
    state_d = state_q;
    if (expire) begin
      unique case (state_q)
        MAIN_GRN:
          if (sensor | wpend_q)
            state_d = MAIN_YEL;
        MAIN_YEL: state_d = ALLRED1;
        ALLRED1:
          state_d = wpend_q ? WALK : SIDE_GRN;
        WALK:
          state_d = sensor ? SIDE_GRN : ALLRED2;
        SIDE_GRN: state_d = SIDE_YEL;
        SIDE_YEL: state_d = ALLRED2;
        default:  state_d = MAIN_GRN;
      endcase
    end
    load_d = (state_d != state_q);
    // Entering WALK serves the request; clear beats set.
    if (state_d == WALK && state_q != WALK)
      wpend_d = 1'b0;
    else if (walk_req && state_q != WALK)
      wpend_d = 1'b1;
    else
      wpend_d = wpend_q;
  end

  always_comb begin
    main_light = RED;
    side_light = RED;
    walk_light = 1'b0;
    unique case (state_q)
      MAIN_GRN: main_light = GRN;
      MAIN_YEL: main_light = YEL;
      SIDE_GRN: side_light = GRN;
      SIDE_YEL: side_light = YEL;
      WALK:     walk_light = 1'b1;
      default:  ;
    endcase
  end

  assign walk_pend = wpend_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: random + directed bench for traffic_ctrl.
// Phase-level reference model compared every cycle.
module tb_traffic_ctrl;

  logic       clk = 1'b1;
  logic       rst = 1'b0;
  logic       tick;
  logic       sensor = 1'b0;
  logic       walk_req = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_light;
  logic       walk_pend;
  logic [3:0] timer_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int sb = 0;
  int tick_mode = 0;
  logic rnd_tick = 1'b1;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  traffic_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .sensor     (sensor),
    .walk_req   (walk_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk_light (walk_light),
    .walk_pend  (walk_pend),
    .timer_out  (timer_out)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rnd_tick <= ($urandom % 3) != 0;
  end

  assign tick = (tick_mode == 0) ? 1'b1 :
                (tick_mode == 1) ? ((cyc % 4) == sb) :
                rnd_tick;

  // Reference model: phase id, cycles since entry, count
  localparam int P_MG = 0, P_MY = 1, P_A1 = 2, P_W = 3;
  localparam int P_SG = 4, P_SY = 5, P_A2 = 6;

  int ph = P_MG;
  int age = 0;
  int tm = 15;
  logic wp = 1'b0;

  function automatic int dur(input int p);
    case (p)
      P_MG: return 8;
      P_MY, P_SY: return 3;
      P_W: return 5;
      P_SG: return 6;
      default: return 1;
    endcase
  endfunction

  // Phase after this edge; leaving needs a loaded, expired count.
  function automatic int nx(input int p, input int a,
                            input int t, input logic s,
                            input logic w);
    if (a == 0 || t != 0) return p;
    case (p)
      P_MG: return (s || w) ? P_MY : P_MG;
      P_MY: return P_A1;
      P_A1: return w ? P_W : P_SG;
      P_W:  return s ? P_SG : P_A2;
      P_SG: return P_SY;
      P_SY: return P_A2;
      default: return P_MG;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph  <= P_MG;
      age <= 0;
      tm  <= 15;
      wp  <= 1'b0;
    end else begin
      ph  <= nx(ph, age, tm, sensor, wp);
      age <= (nx(ph, age, tm, sensor, wp) != ph) ? 0 : 1;
      tm  <= (age == 0) ? dur(ph) :
             (tick && tm > 0) ? tm - 1 : tm;
      wp  <= (nx(ph, age, tm, sensor, wp) == P_W && ph != P_W)
             ? 1'b0
             : (walk_req && ph != P_W) ? 1'b1 : wp;
    end
  end

  function automatic logic [2:0] lite(input int p,
                                      input int g,
                                      input int y);
    if (p == g) return 3'b001;
    if (p == y) return 3'b010;
    return 3'b100;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_main", main_light, lite(ph, P_MG, P_MY));
      chk("m_side", side_light, lite(ph, P_SG, P_SY));
      chk("m_walk", walk_light, int'(ph == P_W));
      chk("m_pend", walk_pend, wp);
      chk("m_timer", timer_out, tm);
    end
  end

  localparam logic [6:0] O_MG = 7'b001_100_0;
  localparam logic [6:0] O_MY = 7'b010_100_0;
  localparam logic [6:0] O_AR = 7'b100_100_0;
  localparam logic [6:0] O_W  = 7'b100_100_1;
  localparam logic [6:0] O_SG = 7'b100_001_0;
  localparam logic [6:0] O_SY = 7'b100_010_0;

  function automatic logic [6:0] obs();
    return {main_light, side_light, walk_light};
  endfunction

  // Count consecutive samples showing pat, from now on.
  task automatic dwell(input logic [6:0] pat, input int exp,
                       input string nm);
    int c;
    c = 0;
    while (obs() == pat && c < 200) begin
      c++;
      @(negedge clk);
    end
    chk(nm, c, exp);
  endtask

  // Leaves the caller on the negedge where rst drops.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb = cyc % 4;
  endtask

  initial begin
    int k;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_main", main_light, 1);
    chk("rst_side", side_light, 4);
    chk("rst_walk", walk_light, 0);
    chk("rst_pend", walk_pend, 0);
    chk("rst_timer", timer_out, 15);
    rst = 1'b0;
    @(negedge clk);
    chk("timer_load", timer_out, 8);

    repeat (38) @(negedge clk);
    chk("idle_main", main_light, 1);
    chk("idle_timer", timer_out, 0);
    sensor = 1'b1;
    @(negedge clk);
    chk("idle_exit", main_light, 2);

    do_reset();
    dwell(O_MG, 10, "full_mg");
    dwell(O_MY, 5, "full_my");
    dwell(O_AR, 3, "full_a1");
    dwell(O_SG, 8, "full_sg");
    dwell(O_SY, 5, "full_sy");
    dwell(O_AR, 3, "full_a2");
    chk("full_back", obs(), O_MG);

    k = 0;
    while (obs() != O_SG && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk("reach_side", int'(obs() == O_SG), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_main", main_light, 1);
    chk("mid_side", side_light, 4);
    chk("mid_pend", walk_pend, 0);
    chk("mid_walk", walk_light, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_timer", timer_out, 8);

    sensor = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    walk_req = 1'b1;
    @(negedge clk);
    walk_req = 1'b0;
    chk("walk_set", walk_pend, 1);
    dwell(O_MG, 6, "walk_mg");
    dwell(O_MY, 5, "walk_my");
    dwell(O_AR, 3, "walk_a1");
    chk("walk_clr", walk_pend, 0);
    dwell(O_W, 7, "walk_w");
    dwell(O_AR, 3, "walk_a2");
    chk("walk_back", obs(), O_MG);

    do_reset();
    walk_req = 1'b1;
    @(negedge clk);
    walk_req = 1'b0;
    dwell(O_MG, 9, "sim_mg");
    dwell(O_MY, 5, "sim_my");
    repeat (2) @(negedge clk);
    walk_req = 1'b1;
    @(negedge clk);
    walk_req = 1'b0;
    chk("sim_inwalk", obs(), O_W);
    chk("sim_clrwin", walk_pend, 0);
    repeat (2) @(negedge clk);
    walk_req = 1'b1;
    @(negedge clk);
    walk_req = 1'b0;
    chk("sim_ignore", walk_pend, 0);
    dwell(O_W, 4, "sim_w");
    dwell(O_AR, 3, "sim_a2");
    repeat (20) @(negedge clk);
    chk("sim_nowalk", obs(), O_MG);
    chk("sim_pend", walk_pend, 0);

    tick_mode = 1;
    sensor = 1'b1;
    do_reset();
    dwell(O_MG, 34, "sparse_mg");
    dwell(O_MY, 12, "sparse_my");

    tick_mode = 2;
    repeat (1500) begin
      @(negedge clk);
      sensor = ($urandom % 4) == 0;
      walk_req = ($urandom % 8) == 0;
      rst = ($urandom % 300) == 0;
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Moore-style sequencer for a two-road intersection with a pedestrian crossing. It owns one instance of the team's down-counting `timer` block. It loads that timer with a per-phase duration, counts it down on a prescaled `tick` enable, and advances the light phase when the count reaches zero. It sits between the board's tick prescaler and button/sensor synchronizers on one side and the light/LED drivers on the other.

## Interface
- `N`, 4: timer width in bits. Every duration must be ≤ 2^N−1.
- `T_GREEN`, 8: minimum main-road green, in ticks.
- `T_YEL`, 3: yellow duration for either road, in ticks.
- `T_ALLRED`, 1: all-red clearance, in ticks.
- `T_SIDE`, 6: side-road green, in ticks.
- `T_WALK`, 5: pedestrian walk phase, in ticks.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tick` in 1: one-cycle count-enable pulse, synchronous to `clk`.
- `sensor` in 1: side-road car present (level, pre-synchronized).
- `walk_req` in 1: pedestrian button (pre-synchronized, any width pulse).
- `main_light` out 3: {R,Y,G} one-hot.
- `side_light` out 3: {R,Y,G} one-hot.
- `walk_light` out 1: walk indicator.
- `walk_pend` out 1: latched, not-yet-served walk request.
- `timer_out` out N: internal timer count, for debug only.

## Operation
- States: MAIN_GRN, MAIN_YEL, ALLRED1, WALK, SIDE_GRN, SIDE_YEL, ALLRED2.
- Registers:
  - `state`.
  - `load_q`: set on every state change and by reset.
  - `walk_pend`.
- Timer control:
  - `load = load_q`.
  - `en = tick & ~load_q`.
  - `init` is the duration for the current state, decoded combinationally. Both yellow states use T_YEL; both all-red states use T_ALLRED.
- `expire = (timer_out == 0) & ~load_q`.
- Transitions, taken only on `expire`; otherwise the FSM holds:
  - MAIN_GRN → MAIN_YEL if `sensor | walk_pend`. Otherwise stay in MAIN_GRN with no reload; the timer rests at 0, and the exit is taken in the first cycle a request is present.
  - MAIN_YEL → ALLRED1.
  - ALLRED1 → WALK if `walk_pend`, else → SIDE_GRN.
  - WALK → SIDE_GRN if `sensor`, else → ALLRED2.
  - SIDE_GRN → SIDE_YEL.
  - SIDE_YEL → ALLRED2.
  - ALLRED2 → MAIN_GRN.
- Light decode:
  - Main light: green in MAIN_GRN, yellow in MAIN_YEL, red otherwise.
  - Side light: green in SIDE_GRN, yellow in SIDE_YEL, red otherwise.
  - `walk_light` = 1 only in WALK.
- `walk_pend`:
  - Set by `walk_req` in any state except WALK.
  - Cleared on the edge that enters WALK. Clear wins over a simultaneous `walk_req`.
  - `walk_req` while in WALK is ignored.
- Reset, at any time including mid-phase, forces all of the following asynchronously:
  - `state` = MAIN_GRN, `load_q` = 1, `walk_pend` = 0.
  - The timer's own reset sets it to all-ones.
  - Resulting outputs: `main_light` = 001, `side_light` = 100, `walk_light` = 0.

## Timing
- Phase dwell with `tick` every cycle is D+2 cycles, broken down as:
  - Entry edge: `load_q` = 1.
  - +1: timer = D.
  - +1+D: timer = 0.
  - +2+D: next state.
- With sparse `tick`, dwell is D ticks plus 2 cycles. Ticks during the load cycle are not counted.
- D = 0 is legal: dwell is 2 cycles.
- Lights change on the same edge as `state`. No output glitch occurs, because outputs are decoded from registers only.
- No two conflicting greens are ever present. Every green-to-green path passes through yellow and all-red.

## Structure
- The shared package holds:
  - The state encoding enum.
  - The light encodings RED=100, YEL=010, GRN=001.
- Sub-module: `timer` (width N, signals load/en/init, saturates at 0). It is instantiated once and is not modified.
- The controller is a single FSM plus the `walk_pend` and `load_q` flops.

## Test plan
Default parameters; `tick` = 1 every cycle unless stated.
- **Reset state:** hold `rst` high, then mid-run assert `rst` while in SIDE_GRN → immediately `main_light` = 001, `side_light` = 100, `walk_pend` = 0; 1 cycle after release `timer_out` = 8.
- **Idle hold:** no `sensor`, no `walk_req` for 50 cycles → stays MAIN_GRN, `timer_out` = 0 from cycle 9. Raising `sensor` at cycle 40 → MAIN_YEL at cycle 41.
- **Full side cycle:** `sensor` = 1 held → dwells MAIN_GRN 10, MAIN_YEL 5, ALLRED1 3, SIDE_GRN 8, SIDE_YEL 5, ALLRED2 3 cycles, then back to MAIN_GRN.
- **Walk request:** 1-cycle `walk_req` at cycle 3, `sensor` = 0 → `walk_pend` = 1 at cycle 4; path MAIN_YEL → ALLRED1 → WALK (7 cycles, `walk_light` = 1, `walk_pend` = 0) → ALLRED2 → MAIN_GRN.
- **Simultaneous clear/set:** `walk_req` asserted on the edge entering WALK, and again mid-WALK → `walk_pend` remains 0 after WALK; no second WALK phase.
- **Sparse tick:** `tick` every 4th cycle, `sensor` = 1 → MAIN_YEL lasts 3 ticks + 2 cycles; a `tick` coincident with `load_q` = 1 does not decrement.
